// File: rtl/apb_delayer_pkg.sv
// Shared types and defaults for the APB rate delayer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_delayer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DELAY = 2'd2
  } state_e;

  // Fixed-point defaults: ratio 4.7363 at a denominator of 100_000
  localparam int unsigned DEF_SCALE = 100_000;
  localparam int unsigned DEF_RS    = 473_630;
  localparam int unsigned DEF_CNT_W = 64;

endpackage

// File: rtl/rate_accum.sv
// Saturating fixed-point accumulator: adds a ratio per device wait, subtracts SCALE per stall.
// Latency: 1 cycle from add_i/sub_i to updated ge_scale_o.
// Backpressure: none; add_i has priority over sub_i, and sub_i is ignored below SCALE.
module rate_accum #(
  parameter int unsigned CNT_W = 64,
  parameter int unsigned SCALE = 100_000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             add_i,
  input  logic [CNT_W-1:0] add_val_i,
  input  logic             sub_i,
  output logic             ge_scale_o
);

  localparam logic [CNT_W-1:0] SCALE_C = CNT_W'(SCALE);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   sum;

  assign ge_scale_o = (acc_q >= SCALE_C);

  // Next accumulator value: saturating add, or a single SCALE subtraction
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, add_val_i};
    acc_d = acc_q;
    if (add_i) begin
      acc_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end else if (sub_i && ge_scale_o) begin
      acc_d = acc_q - SCALE_C;
    end
  end

  // Accumulator register; residue is lost on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/apb_rate_delayer.sv
// APB delayer: stretches each device transfer by a fixed-point CPU/device clock ratio.
// Latency: 3 cycles minimum (IDLE, WAIT, DELAY) plus one cycle per accumulated SCALE unit.
// Backpressure: in_pready held low until the device responds and the stall budget drains.
// Optional stats counters enabled by defining APB_RATE_DELAYER_STATS_EN.
module apb_rate_delayer
  import apb_delayer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SCALE  = DEF_SCALE,
  parameter int unsigned RD_RS  = DEF_RS,
  parameter int unsigned WR_RS  = DEF_RS,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
`ifdef APB_RATE_DELAYER_STATS_EN
  ,
  output logic [31:0]         stat_xfers,
  output logic [31:0]         stat_stalls
`endif
);

  localparam logic [CNT_W-1:0] RD_C = CNT_W'(RD_RS);
  localparam logic [CNT_W-1:0] WR_C = CNT_W'(WR_RS);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic              acc_add, acc_sub, acc_ge;

  // Setup phase passes straight through; reset_n gating keeps the device deselected in reset
  assign out_paddr   = in_paddr;
  assign out_pprot   = in_pprot;
  assign out_pwrite  = in_pwrite;
  assign out_pwdata  = in_pwdata;
  assign out_pstrb   = in_pstrb;
  assign out_psel    = reset_n & (((state_q == IDLE) & in_psel) | (state_q == WAIT));
  assign out_penable = in_penable & (state_q == WAIT);
  assign in_prdata   = prdata_q;
  assign in_pslverr  = pslverr_q;

  rate_accum #(
    .CNT_W (CNT_W),
    .SCALE (SCALE)
  ) u_accum (
    .clock      (clock),
    .reset_n    (reset_n),
    .add_i      (acc_add),
    .add_val_i  (is_wr_q ? WR_C : RD_C),
    .sub_i      (acc_sub),
    .ge_scale_o (acc_ge)
  );

  // Transfer FSM: accumulate while the device waits, then burn whole SCALE units as stalls
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    acc_add   = 1'b0;
    acc_sub   = 1'b0;
    in_pready = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_psel) begin
          is_wr_d = in_pwrite;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (out_pready) begin
          prdata_d  = out_prdata;
          pslverr_d = out_pslverr;
          state_d   = DELAY;
        end else begin
          acc_add = 1'b1;
        end
      end
      DELAY: begin
        if (acc_ge) begin
          acc_sub = 1'b1;
        end else begin
          in_pready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef APB_RATE_DELAYER_STATS_EN
  logic [31:0] xfers_q, stalls_q;

  // Wrapping counters of completed transfers and stall cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (in_pready) xfers_q  <= xfers_q + 32'd1;
      if (acc_sub)   stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_xfers  = xfers_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_apb_rate_delayer.sv
module tb_apb_rate_delayer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Index 0: RD 2.0 / WR 3.0, 64-bit acc.  Index 1: RD 1.5 / WR 9.0, 20-bit acc.
  logic        psel[2], pen[2], pwr[2], opready[2], opslverr[2];
  logic [31:0] paddr[2], pwdata[2], oprdata[2];
  logic [3:0]  pstrb[2];
  logic [2:0]  pprot[2];
  logic        ipready[2], ipslverr[2], opsel[2], open_[2], opwrite[2];
  logic [31:0] iprdata[2], opaddr[2], opwdata[2];
  logic [3:0]  opstrb[2];
  logic [2:0]  opprot[2];
  logic [31:0] sx[2], ss[2];

  apb_rate_delayer #(.SCALE(100_000), .RD_RS(200_000), .WR_RS(300_000), .CNT_W(64)) u_a (
    .clock(clock), .reset_n(reset_n),
    .in_paddr(paddr[0]), .in_psel(psel[0]), .in_penable(pen[0]), .in_pprot(pprot[0]),
    .in_pwrite(pwr[0]), .in_pwdata(pwdata[0]), .in_pstrb(pstrb[0]),
    .in_pready(ipready[0]), .in_prdata(iprdata[0]), .in_pslverr(ipslverr[0]),
    .out_paddr(opaddr[0]), .out_psel(opsel[0]), .out_penable(open_[0]), .out_pprot(opprot[0]),
    .out_pwrite(opwrite[0]), .out_pwdata(opwdata[0]), .out_pstrb(opstrb[0]),
    .out_pready(opready[0]), .out_prdata(oprdata[0]), .out_pslverr(opslverr[0])
`ifdef APB_RATE_DELAYER_STATS_EN
    , .stat_xfers(sx[0]), .stat_stalls(ss[0])
`endif
  );

  apb_rate_delayer #(.SCALE(100_000), .RD_RS(150_000), .WR_RS(900_000), .CNT_W(20)) u_b (
    .clock(clock), .reset_n(reset_n),
    .in_paddr(paddr[1]), .in_psel(psel[1]), .in_penable(pen[1]), .in_pprot(pprot[1]),
    .in_pwrite(pwr[1]), .in_pwdata(pwdata[1]), .in_pstrb(pstrb[1]),
    .in_pready(ipready[1]), .in_prdata(iprdata[1]), .in_pslverr(ipslverr[1]),
    .out_paddr(opaddr[1]), .out_psel(opsel[1]), .out_penable(open_[1]), .out_pprot(opprot[1]),
    .out_pwrite(opwrite[1]), .out_pwdata(opwdata[1]), .out_pstrb(opstrb[1]),
    .out_pready(opready[1]), .out_prdata(oprdata[1]), .out_pslverr(opslverr[1])
`ifdef APB_RATE_DELAYER_STATS_EN
    , .stat_xfers(sx[1]), .stat_stalls(ss[1])
`endif
  );

`ifndef APB_RATE_DELAYER_STATS_EN
  initial begin
    sx[0] = '0; sx[1] = '0; ss[0] = '0; ss[1] = '0;
  end
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  logic [64:0] res[2];

  function automatic logic [64:0] rs_of(input int i, input bit wr);
    if (i == 0) return wr ? 65'd300_000 : 65'd200_000;
    return wr ? 65'd900_000 : 65'd150_000;
  endfunction

  function automatic logic [64:0] max_of(input int i);
    return (i == 0) ? {1'b0, {64{1'b1}}} : 65'd1_048_575;
  endfunction

  // Stalls owed = floor((k*RS + residue)/SCALE) with per-add saturation; remainder carries on
  task automatic model_xfer(input int i, input bit wr, input int k, output int s);
    logic [64:0] a;
    a = res[i];
    repeat (k) begin
      a = a + rs_of(i, wr);
      if (a > max_of(i)) a = max_of(i);
    end
    s = int'(a / 65'd100_000);
    res[i] = a % 65'd100_000;
  endtask

  // ---------------- per-cycle expectations and compare ----------------
  logic        chk_on = 1'b0;
  logic        exp_psel[2], exp_pen[2], exp_rdy[2], exp_err[2];
  logic [31:0] exp_dat[2];

  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("out_psel%0d", i),    opsel[i],    exp_psel[i]);
        chk($sformatf("out_penable%0d", i), open_[i],    exp_pen[i]);
        chk($sformatf("in_pready%0d", i),   ipready[i],  exp_rdy[i]);
        chk($sformatf("in_prdata%0d", i),   iprdata[i],  exp_dat[i]);
        chk($sformatf("in_pslverr%0d", i),  ipslverr[i], exp_err[i]);
        chk($sformatf("fwd%0d", i),
            {opaddr[i], opwdata[i]}, {paddr[i], pwdata[i]});
        chk($sformatf("fwd_ctl%0d", i),
            {opwrite[i], opstrb[i], opprot[i]}, {pwr[i], pstrb[i], pprot[i]});
      end
    end
  end

  task automatic clear_exp();
    for (int i = 0; i < 2; i++) begin
      exp_psel[i] = 0; exp_pen[i] = 0; exp_rdy[i] = 0;
      exp_dat[i] = '0; exp_err[i] = 0; res[i] = '0;
    end
  endtask

  // One APB transfer; the CPU side follows the DUT's in_pready, the model sets expectations
  task automatic xfer(input int i, input bit wr, input int k, input logic [31:0] d,
                      input bit err, output int stl, output int cyc);
    int s;
    model_xfer(i, wr, k, s);
    @(posedge clock); #1;
    psel[i] = 1; pen[i] = 0; pwr[i] = wr;
    paddr[i] = $urandom; pwdata[i] = $urandom;
    pstrb[i] = 4'($urandom); pprot[i] = 3'($urandom);
    opready[i] = 0; oprdata[i] = ~d; opslverr[i] = ~err;
    exp_psel[i] = 1; exp_pen[i] = 0; exp_rdy[i] = 0;
    cyc = 1;
    for (int j = 0; j <= k; j++) begin
      @(posedge clock); #1;
      pen[i] = 1;
      opready[i]  = (j == k);
      oprdata[i]  = (j == k) ? d : ~d;
      opslverr[i] = (j == k) ? err : ~err;
      exp_pen[i] = 1;
      cyc++;
    end
    stl = 0;
    forever begin
      @(posedge clock); #1;
      opready[i] = 0; oprdata[i] = ~d; opslverr[i] = ~err;
      exp_psel[i] = 0; exp_pen[i] = 0; exp_rdy[i] = (stl == s);
      exp_dat[i] = d; exp_err[i] = err;
      cyc++;
      @(negedge clock);
      if (ipready[i]) break;
      stl++;
      if (stl > s + 20) begin
        chk("pready_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++) begin
        psel[i] = 0; pen[i] = 0; opready[i] = 0;
        exp_psel[i] = 0; exp_pen[i] = 0; exp_rdy[i] = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 0; psel[0] = 1; pen[0] = 1;
    clear_exp();
    repeat (2) @(posedge clock);
    #1;
    psel[0] = 0; pen[0] = 0; reset_n = 1;
  endtask

  // Abandon a read in WAIT through reset; accumulated residue must be lost
  task automatic mid_reset(input int i);
    @(posedge clock); #1;
    psel[i] = 1; pen[i] = 0; pwr[i] = 0; opready[i] = 0;
    exp_psel[i] = 1; exp_pen[i] = 0; exp_rdy[i] = 0;
    @(posedge clock); #1;
    pen[i] = 1; exp_pen[i] = 1;
    @(posedge clock); #1;
    reset_n = 0;
    clear_exp();
    @(posedge clock); #1;
    psel[i] = 0; pen[i] = 0; reset_n = 1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int stl, cyc;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; pen[i] = 0; pwr[i] = 0; opready[i] = 0; opslverr[i] = 0;
      paddr[i] = '0; pwdata[i] = '0; oprdata[i] = '0; pstrb[i] = '0; pprot[i] = '0;
    end
    clear_exp();
    reset_n = 1;
    #1;
    // Reset asserted with the CPU already selecting: nothing may leak through
    reset_n = 0; psel[0] = 1; pen[0] = 1;
    chk_on = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_prdata", iprdata[0], 32'h0);
    chk("reset_psel", opsel[0], 0);
    psel[0] = 0; pen[0] = 0; reset_n = 1;
    idle(1);

    // RD 2.0, two device waits -> 4 stalls
    xfer(0, 0, 2, 32'hDEADBEEF, 0, stl, cyc);
    chk("t2_stalls", stl, 4);
    chk("t2_prdata", iprdata[0], 32'hDEADBEEF);
    // Device ready immediately, acc empty -> pready on 3rd cycle
    xfer(0, 0, 0, 32'h1234_5678, 0, stl, cyc);
    chk("t5_latency", cyc, 3);
    // Write at 3.0 with error response, back-to-back
    xfer(0, 1, 1, 32'hCAFE_0001, 1, stl, cyc);
    chk("t4_stalls", stl, 3);
    chk("t4_slverr", ipslverr[0], 1);
    idle(2);

    // RD 1.5: residue carries 0.5 into the second read
    xfer(1, 0, 1, 32'hA5A5_0001, 0, stl, cyc);
    chk("t3_stalls_a", stl, 1);
    xfer(1, 0, 1, 32'hA5A5_0002, 0, stl, cyc);
    chk("t3_stalls_b", stl, 2);
    xfer(1, 0, 1, 32'hA5A5_0003, 0, stl, cyc);
    chk("t3_residue_zero", stl, 1);
    idle(1);
    mid_reset(1);
    idle(1);
    xfer(1, 0, 1, 32'hA5A5_0004, 0, stl, cyc);
    chk("reset_residue_lost", stl, 1);
    idle(1);

    // 20-bit accumulator saturates at 1_048_575 -> 10 stalls
    do_reset();
    idle(1);
    xfer(1, 1, 2, 32'h5A5A_0005, 0, stl, cyc);
    chk("t6_stalls", stl, 10);
    idle(2);
`ifdef APB_RATE_DELAYER_STATS_EN
    chk("stat_xfers", sx[1], 1);
    chk("stat_stalls", ss[1], 10);
`endif
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
